// File: rtl/param_priority_arbiter.sv
// N-way bus arbiter: fixed-priority or round-robin selection with grant locking
// and a bounded hold time. All outputs are registered; req reaches grant one edge later.
module param_priority_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 4,
    localparam int IDW     = (N > 1) ? $clog2(N) : 1,
    localparam int HW      = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req,
    input  logic           mode,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_id,
    output logic           grant_valid
);

    logic [N-1:0]   grant_q, grant_d;
    logic [IDW-1:0] id_q, id_d;
    logic           valid_q, valid_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [HW-1:0]  hold_q, hold_d;

    logic keep;
    logic win_found;
    int   win_idx;
    int   idx;

    always_comb begin
        keep      = 1'b0;
        win_found = 1'b0;
        win_idx   = 0;
        idx       = 0;
        grant_d   = grant_q;
        id_d      = id_q;
        valid_d   = valid_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;

        keep = valid_q && ((req & grant_q) != '0) &&
               ((MAX_HOLD == 0) || (int'(hold_q) < MAX_HOLD));

        if (!mode) begin
            // Ascending scan so the highest requesting index wins.
            for (int i = 0; i < N; i++) begin
                if (req[i]) begin
                    win_found = 1'b1;
                    win_idx   = i;
                end
            end
        end else begin
            // Descending search from ptr, wrapping below 0 back to N-1.
            for (int k = 0; k < N; k++) begin
                idx = int'(ptr_q) - k;
                if (idx < 0) idx = idx + N;
                if (!win_found && req[idx]) begin
                    win_found = 1'b1;
                    win_idx   = idx;
                end
            end
        end

        if (keep) begin
            if (MAX_HOLD != 0) hold_d = hold_q + HW'(1);
        end else if (win_found) begin
            grant_d          = '0;
            grant_d[win_idx] = 1'b1;
            id_d             = IDW'(win_idx);
            valid_d          = 1'b1;
            hold_d           = HW'(1);
            ptr_d            = (win_idx == 0) ? IDW'(N - 1) : IDW'(win_idx - 1);
        end else begin
            grant_d = '0;
            id_d    = '0;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_q <= '0;
            id_q    <= '0;
            valid_q <= 1'b0;
            ptr_q   <= IDW'(N - 1);
            hold_q  <= '0;
        end else begin
            grant_q <= grant_d;
            id_q    <= id_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    assign grant       = grant_q;
    assign grant_id    = id_q;
    assign grant_valid = valid_q;

endmodule

// File: tb/tb_param_priority_arbiter.sv
// Directed bench for param_priority_arbiter (N=4, MAX_HOLD=4) with hand-computed grants.
module tb_param_priority_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic       mode;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       grant_valid;

    int total = 0;
    int bad   = 0;

    param_priority_arbiter #(.N(4), .MAX_HOLD(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .mode        (mode),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [3:0] g, input logic [1:0] id, input logic v);
        check_eq({tag, ".grant"}, 32'(grant), 32'(g));
        check_eq({tag, ".id"}, 32'(grant_id), 32'(id));
        check_eq({tag, ".valid"}, 32'(grant_valid), 32'(v));
    endtask

    // Pull reset low between edges and confirm outputs clear without a clock edge.
    task automatic async_reset_pulse(input string tag);
        reset = 1'b0;
        #2;
        check_out(tag, 4'b0000, 2'd0, 1'b0);
        reset = 1'b1;
    endtask

    initial begin
        logic [3:0] exp_g;
        int         exp_i;

        reset = 1'b0;
        req   = 4'b1111;
        mode  = 1'b0;

        // Held in reset while req toggles.
        for (int c = 0; c < 4; c++) begin
            req = (c % 2 == 0) ? 4'b1111 : 4'b0000;
            step();
            check_out("rst_hold", 4'b0000, 2'd0, 1'b0);
        end
        req = 4'b1111;
        step();
        check_out("rst_hold_req", 4'b0000, 2'd0, 1'b0);

        reset = 1'b1;
        req   = 4'b0000;
        step();
        check_out("rel_idle0", 4'b0000, 2'd0, 1'b0);
        step();
        check_out("rel_idle1", 4'b0000, 2'd0, 1'b0);

        // Fixed priority with lock.
        mode = 1'b0;
        req  = 4'b0011;
        step();
        check_out("fix_first", 4'b0010, 2'd1, 1'b1);
        req = 4'b1011;
        for (int c = 0; c < 3; c++) begin
            step();
            check_out("fix_lock", 4'b0010, 2'd1, 1'b1);
        end
        step();
        check_out("fix_rearb", 4'b1000, 2'd3, 1'b1);

        req = 4'b0000;
        step();
        check_out("fix_idle", 4'b0000, 2'd0, 1'b0);

        async_reset_pulse("arst_idle");

        // Round-robin rotation with all requesters active.
        mode = 1'b1;
        req  = 4'b1111;
        for (int c = 0; c < 17; c++) begin
            step();
            exp_i = (c < 16) ? 3 - (c / 4) : 3;
            exp_g = 4'b0001 << exp_i;
            check_out($sformatf("rr_%0d", c), exp_g, 2'(exp_i), 1'b1);
        end
        step();
        check_out("rr_17", 4'b1000, 2'd3, 1'b1);

        // Async reset mid-rotation, then fresh arbitration starts at the top.
        async_reset_pulse("arst_rr");
        step();
        check_out("arst_first", 4'b1000, 2'd3, 1'b1);
        step();
        check_out("arst_second", 4'b1000, 2'd3, 1'b1);

        // Owner drop hands straight to the next requester.
        async_reset_pulse("arst_pre_drop");
        req = 4'b0100;
        step();
        check_out("drop_owner", 4'b0100, 2'd2, 1'b1);
        req = 4'b0001;
        step();
        check_out("drop_next", 4'b0001, 2'd0, 1'b1);

        // Sole requester keeps the grant across the hold limit with no gap.
        for (int c = 0; c < 10; c++) begin
            step();
            check_out($sformatf("sole_%0d", c), 4'b0001, 2'd0, 1'b1);
        end

        // Mode change during a lock does not break it.
        req  = 4'b1001;
        mode = 1'b0;
        step();
        check_out("mode_lock", 4'b0001, 2'd0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/param_priority_arbiter.md
# param_priority_arbiter

Parametrised N-requester bus arbiter with selectable fixed-priority or round-robin mode, grant locking and a bounded hold time. Sits between N bus masters and one shared resource and issues a registered one-hot grant each cycle. It generalises the team's 4-way fixed-priority arbiter in three ways: it supports any requester count, adds fairness, and prevents a single master from holding the resource indefinitely.

## Interface
- N, default 4: number of requesters, N ≥ 2; bit N-1 is highest fixed priority.
- MAX_HOLD, default 4: maximum consecutive grant cycles before forced re-arbitration; 0 means unlimited.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  N  request vector; bit i high means requester i wants the resource.
- mode  input  1  arbitration mode: 0 = fixed priority, 1 = round-robin.
- grant  output  N  registered one-hot grant, or all zero.
- grant_id  output  max(1,$clog2(N))  index of the granted requester; 0 when grant_valid is low.
- grant_valid  output  1  high when any grant bit is set.

## Operation
- State:
  - owner (grant register).
  - ptr: round-robin search start index, $clog2(N) bits.
  - hold_cnt: cycles the current owner has held the grant, $clog2(MAX_HOLD+1) bits.
- Each rising edge chooses one of two actions:
  - **Keep:** owner valid, req[owner] high, and (MAX_HOLD = 0 or hold_cnt < MAX_HOLD). Grant unchanged; hold_cnt increments.
  - **Arbitrate:** all other cases. The winner is chosen from req. A new grant loads hold_cnt = 1.
- Fixed mode: winner is the highest set index of req.
- Round-robin mode:
  - Search order is ptr, ptr-1, …, 0, N-1, …, ptr+1 (descending, wrapping).
  - ptr updates to (winner-1) mod N on every grant issued in either mode.
  - The previous owner is therefore lowest priority.
- Hold limit reached with the owner still requesting:
  - Arbitration runs normally.
  - If the owner is the only requester, it is re-granted with hold_cnt = 1 and no gap.
- Locking: a higher-priority request arriving mid-grant does not pre-empt the owner until the keep condition fails.
- No requests: grant = 0, grant_valid = 0, grant_id = 0. ptr and hold_cnt hold their values; hold_cnt is don't-care when idle.
- Mode change: sampled each edge. It never breaks an active lock and affects only the next arbitration.
- Arithmetic:
  - ptr wraps modulo N, with correct wrap for non-power-of-two N.
  - hold_cnt never exceeds MAX_HOLD.

## Timing
- Reset asserted (reset = 0), asynchronously:
  - grant = 0, grant_id = 0, grant_valid = 0.
  - ptr = N-1, hold_cnt = 0.
- First edge after release behaves as fixed priority in both modes.
- Latency: req sampled at edge k drives grant after edge k. That is one cycle; there is no combinational req→grant path.
- Owner drops req before edge k: at edge k the grant moves directly to the next winner. There is no idle cycle if another request is pending.
- Reset asserted mid-grant: outputs clear immediately, not at the next edge. The lock and ptr are lost.
- grant, grant_id and grant_valid always change together on the same edge and are mutually consistent.

## Test plan
All scenarios use N = 4, MAX_HOLD = 4.
- **Reset:** hold reset low, toggle req = 1111.
  - Required: grant = 0000, grant_id = 0, grant_valid = 0 throughout.
  - After release with req = 0000: outputs stay 0.
- **Fixed priority with lock:** mode = 0, req = 0011.
  - Next edge: grant = 0010, id = 1.
  - Then req = 1011: grant stays 0010 for 4 total cycles, then becomes 1000, id = 3.
- **Round-robin rotation:** mode = 1, req = 1111 held.
  - Required sequence: 1000 ×4, 0100 ×4, 0010 ×4, 0001 ×4, then 1000 again.
- **Owner drop:** mode = 1, owner 0100, req changes to 0001.
  - Next edge: grant = 0001, id = 0, grant_valid stays high (no gap).
- **Sole requester at hold limit:** mode = 1, req = 0001 only for 10 cycles.
  - Required: grant = 0001 every cycle, grant_valid never drops.
- **Async reset mid-operation:** during the rotation, pull reset low between edges.
  - Required: outputs clear before the next edge.
  - After release with req = 1111, mode = 1: first grant = 1000.
